// File: rtl/cv_mem_pkg.sv
// Shared types and default sizes for the CV memory responder.
package cv_mem_pkg;

    localparam int ADDR_W    = 26;
    localparam int DATA_W    = 32;
    localparam int RD_LAT    = 2;
    localparam int MEM_WORDS = 1048576;

    // Which side received the most recent grant; drives the tie-break.
    typedef enum logic {
        GNT_READ  = 1'b0,
        GNT_WRITE = 1'b1
    } grant_e;

endpackage : cv_mem_pkg

// File: rtl/cv_lat_pipe.sv
// Resettable fixed-depth delay line for small valid/flag words.
// Exposes the last stage plus the MSB (valid bit) of every stage so the
// parent can tell whether anything is still in flight.
module cv_lat_pipe #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [DEPTH-1:0] msb_taps
);

    logic [W-1:0] stage_reg [DEPTH];

    // Shift din through DEPTH stages; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_taps
            assign msb_taps[gi] = stage_reg[gi][W-1];
        end
    endgenerate

    assign dout = stage_reg[DEPTH-1];

endmodule : cv_lat_pipe

// File: rtl/cv_mem_responder.sv
// Memory-side responder for the CV loader request bus. Arbitrates reads
// and writes onto one single-port SRAM, range-checks addresses and returns
// read data in order with fixed latency.
module cv_mem_responder
    import cv_mem_pkg::*;
#(
    parameter int ADDR_W    = cv_mem_pkg::ADDR_W,
    parameter int DATA_W    = cv_mem_pkg::DATA_W,
    parameter int RD_LAT    = cv_mem_pkg::RD_LAT,
    parameter int MEM_WORDS = cv_mem_pkg::MEM_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rvalid,
    input  logic [ADDR_W-1:0] raddr,
    output logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    input  logic              wvalid,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              wready,
    input  logic              mem_ready,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              oor_err,
    output logic              idle
);

    // One extra bit so the limit itself is representable even when it
    // equals 2**ADDR_W.
    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    grant_e      last_grant_reg;
    grant_e      last_grant_next;
    logic        oor_err_reg;
    logic        oor_err_next;
    logic        r_oor;
    logic        w_oor;
    logic [1:0]  pipe_din;
    logic [1:0]  pipe_dout;
    logic [RD_LAT-1:0] pipe_valid;

    assign r_oor = ({1'b0, raddr} >= MEM_LIMIT);
    assign w_oor = ({1'b0, waddr} >= MEM_LIMIT);

    // Grant: a lone request wins; on a tie the side not granted last time wins.
    always_comb begin
        rready = 1'b0;
        wready = 1'b0;
        if (!rst && mem_ready) begin
            if (rvalid && wvalid) begin
                wready = (last_grant_reg == GNT_READ);
                rready = (last_grant_reg == GNT_WRITE);
            end else begin
                rready = rvalid;
                wready = wvalid;
            end
        end
    end

    // Memory command for the granted request; out-of-range strobes are suppressed.
    always_comb begin
        mem_cs    = (rready && !r_oor) || (wready && !w_oor);
        mem_we    = wready;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            mem_addr  = wready ? waddr : raddr;
            mem_wdata = wdata;
        end
    end

    // Next values for the tie-break history and the sticky range error.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (rready) begin
            last_grant_next = GNT_READ;
        end else if (wready) begin
            last_grant_next = GNT_WRITE;
        end
        oor_err_next = oor_err_reg | (rready & r_oor) | (wready & w_oor);
    end

    // Arbitration history and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GNT_READ;
            oor_err_reg    <= 1'b0;
        end else begin
            last_grant_reg <= last_grant_next;
            oor_err_reg    <= oor_err_next;
        end
    end

    assign oor_err  = oor_err_reg;

    // Each accepted read enters the delay line tagged with its range flag.
    assign pipe_din = {rready, rready & r_oor};

    cv_lat_pipe #(
        .W     (2),
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .din      (pipe_din),
        .dout     (pipe_dout),
        .msb_taps (pipe_valid)
    );

    // Response: out-of-range reads return zero instead of memory data.
    always_comb begin
        rdata_valid = 1'b0;
        rdata       = '0;
        if (!rst) begin
            rdata_valid = pipe_dout[1];
            rdata       = pipe_dout[0] ? '0 : mem_rdata;
        end
    end

    assign idle = ~|pipe_valid & ~rvalid & ~wvalid;

endmodule : cv_mem_responder

// File: tb/tb_cv_mem_responder.sv
// Directed bench for cv_mem_responder with a small RD_LAT=2 SRAM model.
module tb_cv_mem_responder;

    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MW  = 1048576;

    logic          clk;
    logic          rst;
    logic          rvalid;
    logic [AW-1:0] raddr;
    logic          rready;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          wvalid;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wready;
    logic          mem_ready;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          oor_err;
    logic          idle;

    int checks   = 0;
    int failures = 0;

    cv_mem_responder #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (LAT),
        .MEM_WORDS (MW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rvalid      (rvalid),
        .raddr       (raddr),
        .rready      (rready),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .wvalid      (wvalid),
        .waddr       (waddr),
        .wdata       (wdata),
        .wready      (wready),
        .mem_ready   (mem_ready),
        .mem_cs      (mem_cs),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .oor_err     (oor_err),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: word i preloads to 0xA50000ii; non-read cycles return all ones.
    logic [DW-1:0] sram    [0:255];
    logic [DW-1:0] rd_pipe [0:1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) begin
                sram[i] <= 32'hA500_0000 | 32'(i);
            end
        end else if (mem_cs && mem_we) begin
            sram[mem_addr[7:0]] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_cs && !mem_we) ? sram[mem_addr[7:0]] : 32'hFFFF_FFFF;
        rd_pipe[1] <= rd_pipe[0];
    end

    assign mem_rdata = rd_pipe[1];

    // Transaction log, sampled mid-cycle after inputs settle.
    always begin
        @(negedge clk);
        #2;
        if (rready)      $display("%0t RD  addr=%h", $time, raddr);
        if (wready)      $display("%0t WR  addr=%h data=%h", $time, waddr, wdata);
        if (rdata_valid) $display("%0t RSP data=%h", $time, rdata);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rvalid = 1'b1; wvalid = 1'b1; raddr = 26'h10; waddr = 26'h11;
        wdata = 32'h0; mem_ready = 1'b1;
        cyc(); cyc(); #1;
        checks++; if (rready !== 1'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0", rready); end
        checks++; if (wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b exp=0", wready); end
        checks++; if (mem_cs !== 1'b0) begin failures++; $display("FAIL reset_mem_cs got=%b exp=0", mem_cs); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (mem_addr !== 26'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL reset_rdata_valid got=%b exp=0", rdata_valid); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (oor_err !== 1'b0) begin failures++; $display("FAIL reset_oor_err got=%b exp=0", oor_err); end
        cyc(); rst = 1'b0; rvalid = 1'b0; wvalid = 1'b0; #1;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
    endtask

    task automatic test_read_stream();
        logic [DW-1:0] exp_data [3];
        int rsp_count;
        exp_data[0] = 32'hA500_0010; exp_data[1] = 32'hA500_0011; exp_data[2] = 32'hA500_0012;
        rsp_count = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            rvalid = (c < 3);
            raddr  = 26'h10 + 26'(c);
            #1;
            if (c < 3) begin
                checks++; if (rready !== 1'b1) begin failures++; $display("FAIL stream_rready c=%0d got=%b exp=1", c, rready); end
                checks++; if (mem_addr !== 26'h10 + 26'(c)) begin failures++; $display("FAIL stream_mem_addr c=%0d got=%h exp=%h", c, mem_addr, 26'h10 + 26'(c)); end
            end
            if (c >= 2 && c <= 4) begin
                checks++; if (rdata_valid !== 1'b1 || rdata !== exp_data[c-2]) begin failures++; $display("FAIL stream_rdata c=%0d got=%b/%h exp=1/%h", c, rdata_valid, rdata, exp_data[c-2]); end
            end else begin
                checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL stream_no_rsp c=%0d got=%b exp=0", c, rdata_valid); end
            end
            if (rdata_valid === 1'b1) rsp_count++;
        end
        checks++; if (rsp_count != 3) begin failures++; $display("FAIL stream_rsp_count got=%0d exp=3", rsp_count); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL stream_idle got=%b exp=1", idle); end
    endtask

    task automatic test_tie();
        logic [3:0] exp_w;
        exp_w = 4'b0101;   // bit k: write expected on tie cycle k (W,R,W,R)
        cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            rvalid = 1'b1; wvalid = 1'b1; raddr = 26'h30; waddr = 26'h31; wdata = 32'h0000_1000 + 32'(k);
            #1;
            checks++; if (wready !== exp_w[k] || rready !== ~exp_w[k]) begin failures++; $display("FAIL tie_grant k=%0d got=w%b r%b exp=w%b r%b", k, wready, rready, exp_w[k], ~exp_w[k]); end
            checks++; if (mem_we !== exp_w[k]) begin failures++; $display("FAIL tie_mem_we k=%0d got=%b exp=%b", k, mem_we, exp_w[k]); end
        end
        cyc(); rvalid = 1'b0; wvalid = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_busy();
        for (int c = 0; c < 3; c++) begin
            cyc(); mem_ready = 1'b0; rvalid = 1'b1; raddr = 26'h12; #1;
            checks++; if (rready !== 1'b0 || mem_cs !== 1'b0) begin failures++; $display("FAIL busy_hold c=%0d got=r%b cs%b exp=r0 cs0", c, rready, mem_cs); end
        end
        cyc(); mem_ready = 1'b1; #1;
        checks++; if (rready !== 1'b1 || mem_cs !== 1'b1) begin failures++; $display("FAIL busy_release got=r%b cs%b exp=r1 cs1", rready, mem_cs); end
        cyc(); rvalid = 1'b0; #1;
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL busy_early got=%b exp=0", rdata_valid); end
        cyc(); #1;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hA500_0012) begin failures++; $display("FAIL busy_rdata got=%b/%h exp=1/a5000012", rdata_valid, rdata); end
    endtask

    task automatic test_write_read();
        cyc(); wvalid = 1'b1; waddr = 26'h20; wdata = 32'hDEAD_BEEF; #1;
        checks++; if (wready !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL wr_cmd got=w%b cs%b we%b exp=1,1,1", wready, mem_cs, mem_we); end
        checks++; if (mem_addr !== 26'h20 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_bus got=%h/%h exp=20/deadbeef", mem_addr, mem_wdata); end
        cyc(); wvalid = 1'b0; rvalid = 1'b1; raddr = 26'h20; #1;
        checks++; if (rready !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_after_wr got=r%b we%b exp=r1 we0", rready, mem_we); end
        cyc(); rvalid = 1'b0; #1;
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL rd_after_wr_early got=%b exp=0", rdata_valid); end
        cyc(); #1;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_after_wr_data got=%b/%h exp=1/deadbeef", rdata_valid, rdata); end
    endtask

    task automatic test_oor();
        cyc(); rvalid = 1'b1; raddr = 26'h10_0000; #1;
        checks++; if (rready !== 1'b1 || mem_cs !== 1'b0) begin failures++; $display("FAIL oor_rd_cmd got=r%b cs%b exp=r1 cs0", rready, mem_cs); end
        cyc(); rvalid = 1'b0; #1;
        checks++; if (oor_err !== 1'b1) begin failures++; $display("FAIL oor_err_set got=%b exp=1", oor_err); end
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL oor_rd_early got=%b exp=0", rdata_valid); end
        cyc(); #1;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL oor_rd_data got=%b/%h exp=1/00000000", rdata_valid, rdata); end
        cyc(); wvalid = 1'b1; waddr = 26'h10_0020; wdata = 32'h1234_5678; #1;
        checks++; if (wready !== 1'b1 || mem_cs !== 1'b0) begin failures++; $display("FAIL oor_wr_cmd got=w%b cs%b exp=w1 cs0", wready, mem_cs); end
        cyc(); wvalid = 1'b0; rvalid = 1'b1; raddr = 26'h0F_FFFF; #1;
        checks++; if (mem_cs !== 1'b1 || mem_addr !== 26'h0F_FFFF) begin failures++; $display("FAIL last_word_cmd got=cs%b %h exp=cs1 0fffff", mem_cs, mem_addr); end
        cyc(); raddr = 26'h20; #1;
        checks++; if (rready !== 1'b1) begin failures++; $display("FAIL oor_reread got=%b exp=1", rready); end
        cyc(); rvalid = 1'b0; #1;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hA500_00FF) begin failures++; $display("FAIL last_word_data got=%b/%h exp=1/a50000ff", rdata_valid, rdata); end
        cyc(); #1;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL oor_wr_dropped got=%b/%h exp=1/deadbeef", rdata_valid, rdata); end
        checks++; if (oor_err !== 1'b1) begin failures++; $display("FAIL oor_err_sticky got=%b exp=1", oor_err); end
    endtask

    task automatic test_reset_mid();
        cyc(); rvalid = 1'b1; raddr = 26'h10;
        cyc(); raddr = 26'h11;
        cyc(); rvalid = 1'b0; rst = 1'b1; #1;
        checks++; if (rdata_valid !== 1'b0 || rdata !== 32'h0) begin failures++; $display("FAIL midrst_gate got=%b/%h exp=0/00000000", rdata_valid, rdata); end
        cyc(); rst = 1'b0; #1;
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL midrst_flush1 got=%b exp=0", rdata_valid); end
        checks++; if (oor_err !== 1'b0) begin failures++; $display("FAIL midrst_oor_clr got=%b exp=0", oor_err); end
        cyc(); #1;
        checks++; if (rdata_valid !== 1'b0) begin failures++; $display("FAIL midrst_flush2 got=%b exp=0", rdata_valid); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL midrst_idle got=%b exp=1", idle); end
        cyc(); rvalid = 1'b1; wvalid = 1'b1; raddr = 26'h40; waddr = 26'h41; wdata = 32'h5; #1;
        checks++; if (wready !== 1'b1 || rready !== 1'b0) begin failures++; $display("FAIL midrst_first_tie got=w%b r%b exp=w1 r0", wready, rready); end
        cyc(); rvalid = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rvalid = 1'b0; wvalid = 1'b0; raddr = '0; waddr = '0; wdata = '0; mem_ready = 1'b1;
        test_reset();
        test_read_stream();
        test_tie();
        test_busy();
        test_write_read();
        test_oor();
        test_reset_mid();
        cyc(); cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cv_mem_responder
